// File: rtl/param_symbol_serializer_pkg.sv
// Shared serdes definitions for the encryptor-to-modulator path:
// cipher block width, symbol widths of the supported constellations
// and the serializer state encoding.
package zmodem_serdes_pkg;

    localparam int AES_BLOCK_W = 128;

    localparam int SYM_W_QPSK  = 2;
    localparam int SYM_W_QAM16 = 4;
    localparam int SYM_W_QAM64 = 6;

    typedef enum logic {
        IDLE = 1'b0,
        TX   = 1'b1
    } ser_state_t;

endpackage

// File: rtl/param_symbol_serializer_if.sv
// Block/symbol handshake bundle between the encryptor, the serializer
// and the modulator. The slave modport is the serializer's view.
interface param_symbol_serializer_if
    import zmodem_serdes_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W,
    parameter int SYM_W   = SYM_W_QPSK
);

    logic [BLOCK_W-1:0] cipher_data;
    logic               load_en;
    logic               buffer_ready;
    logic [SYM_W-1:0]   symbol_data;
    logic               symbol_valid;
    logic               mod_req;
    logic               block_done;
    logic               overrun;

    modport slave (
        input  cipher_data,
        input  load_en,
        input  mod_req,
        output buffer_ready,
        output symbol_data,
        output symbol_valid,
        output block_done,
        output overrun
    );

    modport master (
        output cipher_data,
        output load_en,
        output mod_req,
        input  buffer_ready,
        input  symbol_data,
        input  symbol_valid,
        input  block_done,
        input  overrun
    );

endinterface

// File: rtl/param_symbol_serializer_shift.sv
// Active-path shift register: loads a whole block, presents one symbol
// from the selected end and counts the symbols still to come after it.
module sym_shift_unit
    import zmodem_serdes_pkg::*;
#(
    parameter int BLOCK_W   = AES_BLOCK_W,
    parameter int SYM_W     = SYM_W_QPSK,
    parameter bit MSB_FIRST = 1'b1,
    parameter int NSYM      = BLOCK_W / SYM_W,
    parameter int CNT_W     = (NSYM > 1) ? $clog2(NSYM) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic               shift,
    input  logic [BLOCK_W-1:0] load_data,
    output logic [SYM_W-1:0]   sym,
    output logic [CNT_W-1:0]   cnt
);

    logic [BLOCK_W-1:0] shreg;

    // Clear wins so an idle serializer always presents a zero symbol.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= load_data;
            cnt   <= CNT_W'(NSYM - 1);
        end else if (shift) begin
            shreg <= MSB_FIRST ? (shreg << SYM_W) : (shreg >> SYM_W);
            cnt   <= cnt - CNT_W'(1);
        end
    end

    if (MSB_FIRST) begin : g_msb
        assign sym = shreg[BLOCK_W-1 -: SYM_W];
    end else begin : g_lsb
        assign sym = shreg[SYM_W-1:0];
    end

endmodule

// File: rtl/param_symbol_serializer.sv
// Cipher block to symbol serializer with a one-block holding register so
// the next block can be queued during transmission and streamed gaplessly.
module param_symbol_serializer
    import zmodem_serdes_pkg::*;
#(
    parameter int BLOCK_W   = AES_BLOCK_W,
    parameter int SYM_W     = SYM_W_QPSK,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    param_symbol_serializer_if.slave  bus
);

    localparam int NSYM  = BLOCK_W / SYM_W;
    localparam int CNT_W = (NSYM > 1) ? $clog2(NSYM) : 1;

    if (BLOCK_W % SYM_W != 0) begin : g_bad_width
        $error("BLOCK_W must be a multiple of SYM_W");
    end

    ser_state_t         state;
    logic [BLOCK_W-1:0] hold_reg;
    logic               hold_full;
    logic               block_done_q;
    logic               overrun_q;

    logic [CNT_W-1:0]   cnt;
    logic [SYM_W-1:0]   sym;

    logic               accept;
    logic               consume;
    logic               last_sym;
    logic               su_load;
    logic               su_shift;
    logic               su_clear;
    logic [BLOCK_W-1:0] su_data;

    assign accept   = bus.load_en && !hold_full;
    assign consume  = (state == TX) && bus.mod_req;
    assign last_sym = consume && (cnt == '0);

    // The active register reloads from idle or at a block boundary; the held
    // block has precedence over a simultaneous fresh load at the boundary.
    assign su_load  = ((state == IDLE) && accept) || (last_sym && (hold_full || accept));
    assign su_data  = (last_sym && hold_full) ? hold_reg : bus.cipher_data;
    assign su_shift = consume && (cnt != '0);
    assign su_clear = last_sym && !hold_full && !accept;

    sym_shift_unit #(
        .BLOCK_W   (BLOCK_W),
        .SYM_W     (SYM_W),
        .MSB_FIRST (MSB_FIRST),
        .NSYM      (NSYM),
        .CNT_W     (CNT_W)
    ) u_active (
        .clk       (clk),
        .reset     (reset),
        .load      (su_load),
        .clear     (su_clear),
        .shift     (su_shift),
        .load_data (su_data),
        .sym       (sym),
        .cnt       (cnt)
    );

    // Transmit FSM, holding register management and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hold_reg     <= '0;
            hold_full    <= 1'b0;
            block_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            block_done_q <= last_sym;
            overrun_q    <= bus.load_en && hold_full;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= TX;
                    end
                end
                TX: begin
                    if (last_sym) begin
                        if (hold_full) begin
                            hold_full <= 1'b0;
                        end else if (!accept) begin
                            state <= IDLE;
                        end
                    end else if (accept) begin
                        hold_reg  <= bus.cipher_data;
                        hold_full <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.buffer_ready = !hold_full;
    assign bus.symbol_valid = (state == TX);
    assign bus.symbol_data  = sym;
    assign bus.block_done   = block_done_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_param_symbol_serializer.sv
// Directed bench for the symbol serializer: a QPSK MSB-first instance for
// streaming, back-to-back, overrun, stall and reset cases, and a 16-QAM
// LSB-first instance for bit-order checking.
module tb_param_symbol_serializer;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [127:0] BLK_T1 = 128'hC000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] BLK_T2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] BLK_X  = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
    localparam logic [127:0] BLK_Y  = 128'hFEDC_BA98_7654_3210_A5A5_5A5A_3C3C_C3C3;
    localparam logic [127:0] BLK_Z  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    param_symbol_serializer_if #(.BLOCK_W(128), .SYM_W(2)) bus_a ();
    param_symbol_serializer_if #(.BLOCK_W(128), .SYM_W(4)) bus_b ();

    param_symbol_serializer #(.BLOCK_W(128), .SYM_W(2), .MSB_FIRST(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    param_symbol_serializer #(.BLOCK_W(128), .SYM_W(4), .MSB_FIRST(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive the QPSK instance's inputs, then advance one clock and settle.
    task automatic applyStimulus(input logic ld, input logic [127:0] data, input logic req);
        bus_a.load_en     = ld;
        bus_a.cipher_data = data;
        bus_a.mod_req     = req;
        @(posedge clk);
        #1;
    endtask

    // k-th QPSK symbol of a block, MSB end first.
    function automatic logic [1:0] msbSym2(input logic [127:0] b, input int idx);
        logic [127:0] t;
        t = b >> (126 - 2 * idx);
        return t[1:0];
    endfunction

    // Consume a full block from the QPSK instance with mod_req held high.
    task automatic drainA(input logic [127:0] blk, input string tag);
        for (int i = 0; i < 64; i++) begin
            checkOutput({tag, "_valid"}, 128'(bus_a.symbol_valid), 128'(1));
            checkOutput({tag, "_sym"}, 128'(bus_a.symbol_data), 128'(msbSym2(blk, i)));
            applyStimulus(1'b0, '0, 1'b1);
        end
    endtask

    initial begin
        int idx;
        int cyc;
        logic rq;

        bus_a.load_en = 1'b0; bus_a.cipher_data = '0; bus_a.mod_req = 1'b0;
        bus_b.load_en = 1'b0; bus_b.cipher_data = '0; bus_b.mod_req = 1'b0;

        // Reset values
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("rst_ready",   128'(bus_a.buffer_ready), 128'(1));
        checkOutput("rst_valid",   128'(bus_a.symbol_valid), 128'(0));
        checkOutput("rst_sym",     128'(bus_a.symbol_data),  128'(0));
        checkOutput("rst_done",    128'(bus_a.block_done),   128'(0));
        checkOutput("rst_overrun", 128'(bus_a.overrun),      128'(0));
        checkOutput("rst_b_valid", 128'(bus_b.symbol_valid), 128'(0));
        reset = 1'b0;

        // Test 1: single QPSK block, MSB first
        $display("[TB] test 1: single QPSK block");
        applyStimulus(1'b1, BLK_T1, 1'b1);
        for (int i = 0; i < 64; i++) begin
            checkOutput("t1_valid", 128'(bus_a.symbol_valid), 128'(1));
            checkOutput("t1_sym", 128'(bus_a.symbol_data),
                        (i == 0) ? 128'(3) : ((i == 63) ? 128'(1) : 128'(0)));
            checkOutput("t1_done_low", 128'(bus_a.block_done), 128'(0));
            applyStimulus(1'b0, '0, 1'b1);
        end
        checkOutput("t1_done",  128'(bus_a.block_done),   128'(1));
        checkOutput("t1_idle",  128'(bus_a.symbol_valid), 128'(0));
        checkOutput("t1_zero",  128'(bus_a.symbol_data),  128'(0));
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t1_done_once", 128'(bus_a.block_done), 128'(0));

        // Test 2: 16-QAM, LSB first
        $display("[TB] test 2: 16-QAM LSB first");
        bus_b.cipher_data = BLK_T2;
        bus_b.load_en     = 1'b1;
        bus_b.mod_req     = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        bus_b.load_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            checkOutput("t2_valid", 128'(bus_b.symbol_valid), 128'(1));
            checkOutput("t2_sym", 128'(bus_b.symbol_data), (i < 16) ? 128'(i) : 128'(31 - i));
            applyStimulus(1'b0, '0, 1'b0);
        end
        checkOutput("t2_done", 128'(bus_b.block_done),   128'(1));
        checkOutput("t2_idle", 128'(bus_b.symbol_valid), 128'(0));
        bus_b.mod_req = 1'b0;

        // Test 3: back-to-back blocks, second loaded at symbol 10
        $display("[TB] test 3: back-to-back blocks");
        applyStimulus(1'b1, BLK_X, 1'b1);
        for (int k = 0; k < 128; k++) begin
            checkOutput("t3_valid", 128'(bus_a.symbol_valid), 128'(1));
            checkOutput("t3_sym", 128'(bus_a.symbol_data),
                        (k < 64) ? 128'(msbSym2(BLK_X, k)) : 128'(msbSym2(BLK_Y, k - 64)));
            checkOutput("t3_done", 128'(bus_a.block_done), (k == 64) ? 128'(1) : 128'(0));
            if (k == 10) checkOutput("t3_ready_pre", 128'(bus_a.buffer_ready), 128'(1));
            if (k == 11 || k == 63) checkOutput("t3_ready_full", 128'(bus_a.buffer_ready), 128'(0));
            if (k == 64) checkOutput("t3_ready_after", 128'(bus_a.buffer_ready), 128'(1));
            applyStimulus(k == 10, BLK_Y, 1'b1);
        end
        checkOutput("t3_done2", 128'(bus_a.block_done),   128'(1));
        checkOutput("t3_idle",  128'(bus_a.symbol_valid), 128'(0));

        // Test 4: overrun with active and held blocks present
        $display("[TB] test 4: overrun");
        applyStimulus(1'b1, BLK_X, 1'b0);
        applyStimulus(1'b1, BLK_Y, 1'b0);
        checkOutput("t4_ready",   128'(bus_a.buffer_ready), 128'(0));
        checkOutput("t4_no_ovr",  128'(bus_a.overrun),      128'(0));
        applyStimulus(1'b1, BLK_Z, 1'b0);
        checkOutput("t4_overrun", 128'(bus_a.overrun),      128'(1));
        checkOutput("t4_hold",    128'(bus_a.symbol_data),  128'(msbSym2(BLK_X, 0)));
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("t4_ovr_once", 128'(bus_a.overrun),     128'(0));
        drainA(BLK_X, "t4_x");
        drainA(BLK_Y, "t4_y");
        checkOutput("t4_idle", 128'(bus_a.symbol_valid), 128'(0));

        // Test 5: random mod_req stalls
        $display("[TB] test 5: handshake stall");
        applyStimulus(1'b1, BLK_Y, 1'b0);
        idx = 0;
        cyc = 0;
        while (idx < 64 && cyc < 400) begin
            checkOutput("t5_valid", 128'(bus_a.symbol_valid), 128'(1));
            checkOutput("t5_sym", 128'(bus_a.symbol_data), 128'(msbSym2(BLK_Y, idx)));
            rq = 1'($urandom_range(0, 1));
            applyStimulus(1'b0, '0, rq);
            if (rq) idx++;
            cyc++;
        end
        checkOutput("t5_count", 128'(idx), 128'(64));
        checkOutput("t5_done",  128'(bus_a.block_done),   128'(1));
        checkOutput("t5_idle",  128'(bus_a.symbol_valid), 128'(0));
        applyStimulus(1'b0, '0, 1'b0);

        // Test 6: reset mid-block with a held block pending
        $display("[TB] test 6: reset mid-block");
        applyStimulus(1'b1, BLK_X, 1'b1);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(k == 5, BLK_Y, 1'b1);
        end
        checkOutput("t6_sym20", 128'(bus_a.symbol_data),  128'(msbSym2(BLK_X, 20)));
        checkOutput("t6_held",  128'(bus_a.buffer_ready), 128'(0));
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b1);
        reset = 1'b0;
        checkOutput("t6_ready",   128'(bus_a.buffer_ready), 128'(1));
        checkOutput("t6_valid",   128'(bus_a.symbol_valid), 128'(0));
        checkOutput("t6_sym",     128'(bus_a.symbol_data),  128'(0));
        checkOutput("t6_done",    128'(bus_a.block_done),   128'(0));
        checkOutput("t6_overrun", 128'(bus_a.overrun),      128'(0));
        applyStimulus(1'b1, BLK_Z, 1'b1);
        drainA(BLK_Z, "t6_z");
        checkOutput("t6_idle", 128'(bus_a.symbol_valid), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
